// File: rtl/probe_capture_pkg.sv
// Shared types for the probe event capture core: capture FSM states and entry width helper.
package probe_capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        DONE      = 2'd3
    } cap_state_t;

    function automatic int ENTRY_W(input int ts_w, input int n_ch);
        return ts_w + n_ch;
    endfunction

endpackage

// File: rtl/probe_sync_filter.sv
// One probe channel: 2-FF synchroniser, followed by an optional glitch filter
// when PROBE_GLITCH_FILTER_EN is defined (otherwise s_o is the synchroniser output).
module probe_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic probe_i,
    output logic s_o
);

    if (FILTER_LEN < 2) begin : g_cfg_err
        $error("probe_sync_filter: FILTER_LEN must be >= 2");
    end

    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= probe_i;
            sync_q <= meta_q;
        end
    end

`ifdef PROBE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN);

    logic          s_q, s_d;
    logic [CW-1:0] run_q, run_d;

    // s only follows after FILTER_LEN consecutive cycles of disagreement
    always_comb begin
        s_d   = s_q;
        run_d = '0;
        if (sync_q != s_q) begin
            if (run_q == CW'(FILTER_LEN - 1)) s_d = sync_q;
            else                              run_d = run_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            run_q <= '0;
        end else begin
            s_q   <= s_d;
            run_q <= run_d;
        end
    end

    assign s_o = s_q;
`else
    assign s_o = sync_q;
`endif

endmodule

// File: rtl/probe_event_capture.sv
// N-channel change-only event capture into a circular {delta, values} buffer with trigger/post-trigger.
// Optional glitch filtering in the per-channel front end is enabled by PROBE_GLITCH_FILTER_EN.
module probe_event_capture
    import probe_capture_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int DEPTH      = 1024,
    parameter  int TS_W       = 14,
    parameter  int FILTER_LEN = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      probe_in,
    input  logic                 arm,
    input  logic [N_CH-1:0]      trig_mask,
    input  logic [AW-1:0]        post_trig,
    input  logic [AW-1:0]        rd_addr,
    output logic [TS_W+N_CH-1:0] rd_data,
    output logic [1:0]           state,
    output logic [AW-1:0]        write_pointer,
    output logic [AW-1:0]        trig_index,
    output logic                 wrapped
);

    localparam int              EW   = ENTRY_W(TS_W, N_CH);
    localparam logic [TS_W-1:0] DMAX = '1;

    logic [N_CH-1:0] s, p_q, edge_v;
    logic            evt, trig, we;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        probe_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .probe_i (probe_in[c]),
            .s_o     (s[c])
        );
    end

    cap_state_t      state_q, state_d;
    logic [TS_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   wp_q, wp_d, trig_q, trig_d, rem_q, rem_d;
    logic            wrapped_q, wrapped_d;
    logic [EW-1:0]   rd_q;
    logic [EW-1:0]   mem [DEPTH];

    assign edge_v = s ^ p_q;
    assign evt    = (|edge_v) || (cnt_q == DMAX);
    assign trig   = |(edge_v & trig_mask);

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        trig_d    = trig_q;
        rem_d     = rem_q;
        wrapped_d = wrapped_q;
        we        = 1'b0;
        cnt_d     = (cnt_q == DMAX) ? cnt_q : cnt_q + TS_W'(1);
        if (arm) begin
            // arm wins over any same-cycle event
            state_d   = ARMED;
            wp_d      = '0;
            cnt_d     = '0;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (evt) begin
                        we = 1'b1;
                        if (wp_q == AW'(DEPTH - 1)) wrapped_d = 1'b1;
                        if (trig) begin
                            // post_trig is AW bits, so it is already <= DEPTH-1 and the
                            // post-trigger run can never reach the trigger entry again
                            trig_d  = wp_q;
                            rem_d   = post_trig;
                            state_d = (post_trig == '0) ? DONE : CAPTURING;
                        end
                    end
                end
                CAPTURING: begin
                    if (evt) begin
                        we    = 1'b1;
                        rem_d = rem_q - AW'(1);
                        if (rem_q == AW'(1)) state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
        if (we) begin
            wp_d  = wp_q + AW'(1);
            cnt_d = TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            p_q       <= '0;
            cnt_q     <= '0;
            wp_q      <= '0;
            trig_q    <= '0;
            rem_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= s;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            trig_q    <= trig_d;
            rem_q     <= rem_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wp_q] <= {cnt_q, s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= mem[rd_addr];
    end

    assign rd_data       = rd_q;
    assign state         = state_q;
    assign write_pointer = wp_q;
    assign trig_index    = trig_q;
    assign wrapped       = wrapped_q;

endmodule

// File: tb/tb_probe_event_capture.sv
// Directed bench for probe_event_capture: instance A (DEPTH=16, TS_W=8) and instance B (DEPTH=16, TS_W=4).
`timescale 1ns/1ps
module tb_probe_event_capture;

    localparam int TSA = 8;
    localparam int TSB = 4;
`ifdef PROBE_GLITCH_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       pa = '0, mask_a = '0;
    logic             arm_a = 1'b0;
    logic [3:0]       post_a = '0, rda = '0;
    logic [TSA+1:0]   rdd_a;
    logic [1:0]       st_a;
    logic [3:0]       wp_a, ti_a;
    logic             wr_a;

    logic [1:0]       pb = '0, mask_b = 2'b01;
    logic             arm_b = 1'b0;
    logic [3:0]       post_b = 4'd3, rdb = '0;
    logic [TSB+1:0]   rdd_b;
    logic [1:0]       st_b;
    logic [3:0]       wp_b, ti_b;
    logic             wr_b;

    probe_event_capture #(.N_CH(2), .DEPTH(16), .TS_W(TSA), .FILTER_LEN(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .probe_in(pa), .arm(arm_a), .trig_mask(mask_a),
        .post_trig(post_a), .rd_addr(rda), .rd_data(rdd_a), .state(st_a),
        .write_pointer(wp_a), .trig_index(ti_a), .wrapped(wr_a)
    );

    probe_event_capture #(.N_CH(2), .DEPTH(16), .TS_W(TSB), .FILTER_LEN(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .probe_in(pb), .arm(arm_b), .trig_mask(mask_b),
        .post_trig(post_b), .rd_addr(rdb), .rd_data(rdd_b), .state(st_b),
        .write_pointer(wp_b), .trig_index(ti_b), .wrapped(wr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm_a();
        arm_a = 1'b1;
        @(negedge clk);
        arm_a = 1'b0;
    endtask

    task automatic read_a(input logic [3:0] a, output logic [31:0] d);
        rda = a;
        @(negedge clk);
        d = 32'(rdd_a);
    endtask

    task automatic read_b(input logic [3:0] a, output logic [31:0] d);
        rdb = a;
        @(negedge clk);
        d = 32'(rdd_b);
    endtask

    logic [31:0] d;
    int exp_e [5];

    initial begin
        tick(3);
        chk("rst_state", 32'(st_a), 0);
        chk("rst_wp", 32'(wp_a), 0);
        chk("rst_trig_index", 32'(ti_a), 0);
        chk("rst_wrapped", 32'(wr_a), 0);
        chk("rst_rd_data", 32'(rdd_a), 0);
        rst_n = 1'b1;
        tick(2);

        // idle: probe activity without arm writes nothing
        for (int i = 0; i < 10; i++) begin
            pa = ~pa;
            tick(6);
        end
        chk("idle_state", 32'(st_a), 0);
        chk("idle_wp", 32'(wp_a), 0);
        chk("idle_wrapped", 32'(wr_a), 0);

        // trigger on ch0 with 3 post-trigger entries; ch1 edge first is pre-trigger
        mask_a = 2'b01;
        post_a = 4'd3;
        pulse_arm_a();
        tick(5);
        pa[1] = 1'b1;
        tick(50); pa[0] = 1'b1;
        tick(50); pa[0] = 1'b0;
        tick(50); pa[0] = 1'b1;
        tick(10);
        chk("cap_state_mid", 32'(st_a), 2);
        tick(40); pa[0] = 1'b0;
        tick(10);
        chk("cap_state_done", 32'(st_a), 3);
        chk("cap_wp", 32'(wp_a), 5);
        chk("cap_trig_index", 32'(ti_a), 1);
        chk("cap_wrapped", 32'(wr_a), 0);
        pa[1] = 1'b0;
        tick(10);
        chk("done_hold_wp", 32'(wp_a), 5);
        chk("done_hold_state", 32'(st_a), 3);
        exp_e[0] = ((7 + FL) << 2) | 2;
        exp_e[1] = (50 << 2) | 3;
        exp_e[2] = (50 << 2) | 2;
        exp_e[3] = (50 << 2) | 3;
        exp_e[4] = (50 << 2) | 2;
        for (int i = 0; i < 5; i++) begin
            read_a(4'(i), d);
            chk($sformatf("cap_entry%0d", i), d, 32'(exp_e[i]));
        end

        // wrap: 20 pre-trigger edges in a 16-deep buffer, then maximum post-trigger run
        post_a = 4'd15;
        pulse_arm_a();
        for (int i = 0; i < 20; i++) begin
            tick(8);
            pa[1] = ~pa[1];
        end
        tick(8);
        chk("wrap_pre_wp", 32'(wp_a), 4);
        chk("wrap_pre_wrapped", 32'(wr_a), 1);
        chk("wrap_pre_state", 32'(st_a), 1);
        pa[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(8);
            pa[1] = ~pa[1];
        end
        tick(8);
        chk("wrap_state", 32'(st_a), 3);
        chk("wrap_wp", 32'(wp_a), 4);
        chk("wrap_trig_index", 32'(ti_a), 4);
        chk("wrap_wrapped", 32'(wr_a), 1);
        read_a(4'd4, d);
        chk("wrap_trig_entry", d, (8 << 2) | 1);
        read_a(4'd3, d);
        chk("wrap_last_entry", d, (8 << 2) | 3);

        // arm in the same cycle as a masked edge while capturing
        post_a = 4'd10;
        pulse_arm_a();
        tick(8);
        pa[0] = 1'b0;
        tick(8);
        chk("arm_mid_state", 32'(st_a), 2);
        chk("arm_mid_wp", 32'(wp_a), 1);
        tick(4);
        pa[0] = 1'b1;
        tick(2 + FL);
        pulse_arm_a();
        chk("arm_edge_state", 32'(st_a), 1);
        chk("arm_edge_wp", 32'(wp_a), 0);
        tick(8);
        chk("arm_edge_state_later", 32'(st_a), 1);
        chk("arm_edge_wp_later", 32'(wp_a), 0);
        read_a(4'd1, d);
        chk("arm_edge_no_write", d, (8 << 2) | 3);

        // short and long pulses on ch0, mask 0 keeps the capture armed
        mask_a = 2'b00;
        pulse_arm_a();
        tick(4);
        pa[0] = 1'b0;
        tick(3);
        pa[0] = 1'b1;
        tick(15);
        chk("pulse3_wp", 32'(wp_a), (FL != 0) ? 0 : 2);
        pa[0] = 1'b0;
        tick(6);
        pa[0] = 1'b1;
        tick(15);
        chk("pulse6_wp", 32'(wp_a), (FL != 0) ? 2 : 4);
        chk("pulse_state", 32'(st_a), 1);

        // keepalive on TS_W=4 with static probes: one entry every 15 cycles, no trigger
        arm_b = 1'b1;
        @(negedge clk);
        arm_b = 1'b0;
        tick(15);
        chk("ka_wp_before", 32'(wp_b), 0);
        tick(1);
        chk("ka_wp_first", 32'(wp_b), 1);
        tick(15);
        chk("ka_wp_second", 32'(wp_b), 2);
        tick(9);
        chk("ka_state", 32'(st_b), 1);
        chk("ka_wp_40", 32'(wp_b), 2);
        read_b(4'd0, d);
        chk("ka_entry0", d, 15 << 2);
        read_b(4'd1, d);
        chk("ka_entry1", d, 15 << 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
